apu_pulse: RTL and testbench

- One NES APU pulse channel: CPU register file ($4000-$4003 or $4004-$4007), 11-bit period register, timer, 8-step duty sequencer, length counter and volume.
- Owns the period that the sweep unit reads. Applies the sweep unit's period-update and mute outputs.
- Drives the sweep unit's control fields.
- Sits between the APU register decoder / frame counter and the mixer.

---
 rtl/apu_pulse_if.sv | 8 +
 rtl/apu_pulse.sv | 145 ++++++++++++++
 tb/tb_apu_pulse.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/apu_pulse_if.sv
// apu_pulse_if: CPU register-write bus into one pulse channel
interface apu_pulse_if;
    logic       reg_we;
    logic [1:0] reg_addr;
    logic [7:0] reg_data;
    modport master (output reg_we, reg_addr, reg_data);
    modport slave  (input  reg_we, reg_addr, reg_data);
endinterface

// File: rtl/apu_pulse.sv
// apu_pulse: NES APU pulse channel; envelope generator built only when APU_PULSE_ENVELOPE_EN is defined
module apu_pulse (
    input  logic        clk,
    input  logic        rst,
    input  logic        apu_cycle,
    input  logic        quarterframe,
    input  logic        halfframe,
    apu_pulse_if.slave  bus,
    input  logic        chan_en,
    output logic [10:0] pulse_period,
    output logic        sweep_en,
    output logic [2:0]  sweep_period,
    output logic        sweep_neg,
    output logic [2:0]  sweep_shift,
    output logic        sweep_reload,
    input  logic [10:0] target_period,
    input  logic        update_pulse_period,
    input  logic        mute,
    output logic        length_active,
    output logic [3:0]  out
);
    localparam logic [7:0] LEN [32] = '{
        8'd10, 8'd254, 8'd20, 8'd2,  8'd40, 8'd4,  8'd80, 8'd6,
        8'd160, 8'd8,  8'd60, 8'd10, 8'd14, 8'd12, 8'd26, 8'd14,
        8'd12, 8'd16,  8'd24, 8'd18, 8'd48, 8'd20, 8'd96, 8'd22,
        8'd192, 8'd24, 8'd72, 8'd26, 8'd16, 8'd28, 8'd32, 8'd30
    };
    localparam logic [7:0] DUTY [4] = '{8'h02, 8'h06, 8'h1E, 8'hF9};
    logic [1:0]  r_duty;
    logic        r_halt;
    logic [3:0]  r_vol;
    logic [7:0]  r_sweep;
    logic        r_sweep_reload;
    logic [10:0] r_period;
    logic [10:0] r_timer;
    logic [2:0]  r_step;
    logic [7:0]  r_length;
    logic [3:0]  r_out;
    logic        w_we0, w_we1, w_we2, w_we3;
    logic [3:0]  w_volume;
    assign w_we0 = bus.reg_we && bus.reg_addr == 2'd0;
    assign w_we1 = bus.reg_we && bus.reg_addr == 2'd1;
    assign w_we2 = bus.reg_we && bus.reg_addr == 2'd2;
    assign w_we3 = bus.reg_we && bus.reg_addr == 2'd3;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_duty         <= '0;
            r_halt         <= 1'b0;
            r_vol          <= '0;
            r_sweep        <= '0;
            r_sweep_reload <= 1'b0;
        end else begin
            r_duty         <= w_we0 ? bus.reg_data[7:6] : r_duty;
            r_halt         <= w_we0 ? bus.reg_data[5] : r_halt;
            r_vol          <= w_we0 ? bus.reg_data[3:0] : r_vol;
            r_sweep        <= w_we1 ? bus.reg_data : r_sweep;
            r_sweep_reload <= w_we1;
        end
    end
    // CPU period writes take priority; a colliding sweep update is discarded
    always_ff @(posedge clk) begin
        if (rst)
            r_period <= '0;
        else if (w_we2)
            r_period <= {r_period[10:8], bus.reg_data};
        else if (w_we3)
            r_period <= {bus.reg_data[2:0], r_period[7:0]};
        else if (update_pulse_period)
            r_period <= target_period;
    end
    // sequencer walks 0,7,6,...,1; period changes never reload the timer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer <= '0;
            r_step  <= '0;
        end else begin
            if (apu_cycle)
                r_timer <= (r_timer == 11'd0) ? r_period : r_timer - 11'd1;
            if (w_we3)
                r_step <= '0;
            else if (apu_cycle && r_timer == 11'd0)
                r_step <= r_step - 3'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst || !chan_en)
            r_length <= '0;
        else if (w_we3)
            r_length <= LEN[bus.reg_data[7:3]];
        else if (halfframe && !r_halt && r_length != 8'd0)
            r_length <= r_length - 8'd1;
    end
`ifdef APU_PULSE_ENVELOPE_EN
    logic       r_const_vol;
    logic       r_start;
    logic [3:0] r_decay;
    logic [3:0] r_div;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_const_vol <= 1'b0;
            r_start     <= 1'b0;
            r_decay     <= '0;
            r_div       <= '0;
        end else begin
            r_const_vol <= w_we0 ? bus.reg_data[4] : r_const_vol;
            if (quarterframe) begin
                if (r_start) begin
                    r_start <= 1'b0;
                    r_decay <= 4'd15;
                    r_div   <= r_vol;
                end else if (r_div == 4'd0) begin
                    r_div <= r_vol;
                    if (r_decay != 4'd0)
                        r_decay <= r_decay - 4'd1;
                    else if (r_halt)
                        r_decay <= 4'd15;
                end else begin
                    r_div <= r_div - 4'd1;
                end
            end
            if (w_we3)
                r_start <= 1'b1;
        end
    end
    assign w_volume = r_const_vol ? r_vol : r_decay;
`else
    logic w_unused;
    assign w_unused = &{1'b0, quarterframe};
    assign w_volume = r_vol;
`endif
    always_ff @(posedge clk) begin
        if (rst)
            r_out <= '0;
        else
            r_out <= (r_length == 8'd0 || mute || !DUTY[r_duty][r_step]) ? 4'd0 : w_volume;
    end
    assign pulse_period  = r_period;
    assign sweep_en      = r_sweep[7];
    assign sweep_period  = r_sweep[6:4];
    assign sweep_neg     = r_sweep[3];
    assign sweep_shift   = r_sweep[2:0];
    assign sweep_reload  = r_sweep_reload;
    assign length_active = r_length != 8'd0;
    assign out           = r_out;
endmodule

// File: tb/tb_apu_pulse.sv
// tb_apu_pulse: directed and random stimulus checked every cycle against a behavioural channel model
module tb_apu_pulse;
    logic        clk = 1'b0;
    logic        rst, apu_cycle, quarterframe, halfframe, chan_en, update_pulse_period, mute;
    logic [10:0] target_period;
    logic [10:0] pulse_period;
    logic        sweep_en, sweep_neg, sweep_reload, length_active;
    logic [2:0]  sweep_period, sweep_shift;
    logic [3:0]  out;
    int n_cmp = 0;
    int n_bad = 0;
    apu_pulse_if bus ();
    apu_pulse dut (
        .clk(clk), .rst(rst), .apu_cycle(apu_cycle), .quarterframe(quarterframe),
        .halfframe(halfframe), .bus(bus.slave), .chan_en(chan_en),
        .pulse_period(pulse_period), .sweep_en(sweep_en), .sweep_period(sweep_period),
        .sweep_neg(sweep_neg), .sweep_shift(sweep_shift), .sweep_reload(sweep_reload),
        .target_period(target_period), .update_pulse_period(update_pulse_period),
        .mute(mute), .length_active(length_active), .out(out)
    );
    always #5 clk = ~clk;
    int len_tbl [32] = '{10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,
                         12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30};
    int wave [4][8] = '{'{0,1,0,0,0,0,0,0}, '{0,1,1,0,0,0,0,0},
                        '{0,1,1,1,1,0,0,0}, '{1,0,0,1,1,1,1,1}};
    int m_duty, m_halt, m_cv, m_vol, m_sw, m_swr, m_period, m_timer, m_pos, m_len, m_out;
    int m_start, m_decay, m_div;
    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        n_cmp++;
        assert (obs === 32'(exp)) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic model();
        int d, a, nout, vol;
        d = int'(bus.reg_data);
        a = int'(bus.reg_addr);
        if (rst) begin
            {m_duty, m_halt, m_cv, m_vol, m_sw, m_swr, m_period, m_timer} = '0;
            {m_pos, m_len, m_out, m_start, m_decay, m_div} = '0;
            return;
        end
`ifdef APU_PULSE_ENVELOPE_EN
        vol = m_cv != 0 ? m_vol : m_decay;
`else
        vol = m_vol;
`endif
        nout = (m_len == 0 || mute || wave[m_duty][m_pos] == 0) ? 0 : vol;
        if (apu_cycle) begin
            if (m_timer == 0) begin
                m_timer = m_period;
                m_pos = (m_pos + 7) % 8;
            end else m_timer--;
        end
        if (!chan_en) m_len = 0;
        else if (bus.reg_we && a == 3) m_len = len_tbl[d / 8];
        else if (halfframe && m_halt == 0 && m_len > 0) m_len--;
`ifdef APU_PULSE_ENVELOPE_EN
        if (quarterframe) begin
            if (m_start != 0) begin
                m_start = 0; m_decay = 15; m_div = m_vol;
            end else if (m_div == 0) begin
                m_div = m_vol;
                if (m_decay > 0) m_decay--;
                else if (m_halt != 0) m_decay = 15;
            end else m_div--;
        end
        if (bus.reg_we && a == 3) m_start = 1;
`endif
        m_swr = (bus.reg_we && a == 1) ? 1 : 0;
        if (bus.reg_we && a == 0) begin
            m_duty = d / 64; m_halt = (d / 32) % 2; m_cv = (d / 16) % 2; m_vol = d % 16;
        end
        if (bus.reg_we && a == 1) m_sw = d;
        if (bus.reg_we && a == 2) m_period = (m_period / 256) * 256 + d;
        else if (bus.reg_we && a == 3) begin
            m_period = (d % 8) * 256 + m_period % 256;
            m_pos = 0;
        end else if (update_pulse_period) m_period = int'(target_period);
        m_out = nout;
    endtask
    task automatic cycle();
        @(posedge clk);
        model();
        @(negedge clk);
        chk("out", 32'(out), m_out);
        chk("pulse_period", 32'(pulse_period), m_period);
        chk("length_active", 32'(length_active), m_len != 0 ? 1 : 0);
        chk("sweep_en", 32'(sweep_en), m_sw / 128);
        chk("sweep_period", 32'(sweep_period), (m_sw / 16) % 8);
        chk("sweep_neg", 32'(sweep_neg), (m_sw / 8) % 2);
        chk("sweep_shift", 32'(sweep_shift), m_sw % 8);
        chk("sweep_reload", 32'(sweep_reload), m_swr);
        bus.reg_we = 1'b0;
        quarterframe = 1'b0;
        halfframe = 1'b0;
        update_pulse_period = 1'b0;
        apu_cycle = ~apu_cycle;
    endtask
    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        bus.reg_we = 1'b1;
        bus.reg_addr = a;
        bus.reg_data = d;
        cycle();
    endtask
    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask
    initial begin
        rst = 1'b1; apu_cycle = 1'b0; quarterframe = 1'b0; halfframe = 1'b0;
        chan_en = 1'b1; update_pulse_period = 1'b0; mute = 1'b0; target_period = '0;
        bus.reg_we = 1'b0; bus.reg_addr = '0; bus.reg_data = '0;
        @(negedge clk);
        run(2);
        rst = 1'b0;
        chk("reset_out", 32'(out), 0);
        chk("reset_len", 32'(length_active), 0);
        wr(2'd0, 8'h3F);
        wr(2'd2, 8'h08);
        wr(2'd3, 8'h08);
        chk("len_loaded", 32'(length_active), 1);
        run(200);
        mute = 1'b1;
        run(60);
        mute = 1'b0;
        run(60);
        target_period = 11'h123;
        update_pulse_period = 1'b1;
        cycle();
        chk("sweep_update", 32'(pulse_period), 'h123);
        target_period = 11'h456;
        update_pulse_period = 1'b1;
        wr(2'd2, 8'h55);
        chk("write_beats_sweep", 32'(pulse_period), 'h155);
        wr(2'd2, 8'h08);
        wr(2'd0, 8'h00);
        wr(2'd3, 8'h18);
        for (int i = 0; i < 3; i++) begin halfframe = 1'b1; cycle(); run(3); end
        chk("len_expired", 32'(length_active), 0);
        wr(2'd0, 8'h20);
        wr(2'd3, 8'h18);
        for (int i = 0; i < 3; i++) begin halfframe = 1'b1; cycle(); run(3); end
        chk("len_halted", 32'(length_active), 1);
        chan_en = 1'b0;
        cycle();
        chk("len_disabled", 32'(length_active), 0);
        chan_en = 1'b1;
        wr(2'd1, 8'hA5);
        chk("sweep_fields", 32'({sweep_en, sweep_period, sweep_neg, sweep_shift}), 'b1_010_0_101);
        cycle();
        chk("sweep_reload_once", 32'(sweep_reload), 0);
        wr(2'd1, 8'h3C);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("midrun_reset", 32'(sweep_reload), 0);
        wr(2'd2, 8'h08);
        for (int k = 0; k < 2; k++) begin
            wr(2'd0, k == 0 ? 8'hC2 : 8'hE2);
            wr(2'd3, 8'h08);
            for (int i = 0; i < 200; i++) begin
                quarterframe = (i % 4 == 0);
                cycle();
            end
        end
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            chan_en = ($urandom_range(0, 63) != 0);
            mute = ($urandom_range(0, 15) == 0);
            quarterframe = ($urandom_range(0, 7) == 0);
            halfframe = ($urandom_range(0, 15) == 0);
            update_pulse_period = ($urandom_range(0, 7) == 0);
            target_period = 11'($urandom_range(0, 40));
            if ($urandom_range(0, 9) == 0) begin
                bus.reg_we = 1'b1;
                bus.reg_addr = 2'($urandom_range(0, 3));
                bus.reg_data = 8'($urandom);
                if (bus.reg_addr == 2'd2) bus.reg_data = 8'($urandom_range(0, 24));
                if (bus.reg_addr == 2'd3) bus.reg_data[2:0] = 3'd0;
            end
            cycle();
        end
        rst = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
